// File: rtl/issue_scoreboard_if.sv
// Decode/execute/writeback signal bundle for the issue scoreboard.
// The scoreboard uses the slave modport. The driving environment uses master.
interface issue_scoreboard_if #(
   parameter int IDX_W = 5
);
   logic             prev_done;
   logic             stall_prev;
   logic             next_stall;
   logic             done_next;
   logic [IDX_W-1:0] read_register_1_in;
   logic             read_register_1_valid_in;
   logic [IDX_W-1:0] read_register_2_in;
   logic             read_register_2_valid_in;
   logic [IDX_W-1:0] write_register_in;
   logic             write_register_valid_in;
   logic [IDX_W-1:0] retire_register;
   logic             retire_valid;
   logic             flush;
   logic             pending_any;
   logic             underflow_error;
   logic [31:0]      stall_cycles;

   modport master (
      output prev_done, next_stall,
      output read_register_1_in, read_register_1_valid_in,
      output read_register_2_in, read_register_2_valid_in,
      output write_register_in, write_register_valid_in,
      output retire_register, retire_valid, flush,
      input  stall_prev, done_next, pending_any, underflow_error, stall_cycles
   );

   modport slave (
      input  prev_done, next_stall,
      input  read_register_1_in, read_register_1_valid_in,
      input  read_register_2_in, read_register_2_valid_in,
      input  write_register_in, write_register_valid_in,
      input  retire_register, retire_valid, flush,
      output stall_prev, done_next, pending_any, underflow_error, stall_cycles
   );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: per-register pending-write counters gate issue from decode to execute.
// Writeback retirements decrement the counters. A flush clears all of them.
module issue_scoreboard #(
   parameter int NUM_REGISTERS           = 32,
   parameter int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS),
   parameter int COUNT_WIDTH             = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   issue_scoreboard_if.slave  sb
);
   localparam logic [REGISTER_INDEXING_WIDTH-1:0] ZERO_IDX = {REGISTER_INDEXING_WIDTH{1'b0}};
   localparam logic [COUNT_WIDTH-1:0]             ZERO_CNT = {COUNT_WIDTH{1'b0}};
   localparam logic [COUNT_WIDTH-1:0]             MAX_CNT  = {COUNT_WIDTH{1'b1}};
   localparam logic [COUNT_WIDTH-1:0]             ONE_CNT  = COUNT_WIDTH'(1);

   logic [COUNT_WIDTH-1:0]   cnt_r [NUM_REGISTERS];
   logic                     underflow_r;
   logic [31:0]              stall_cycles_r;

   logic [NUM_REGISTERS-1:0] inc_s;
   logic [NUM_REGISTERS-1:0] dec_s;
   logic [NUM_REGISTERS-1:0] zero_s;
   logic                     hazard_s;
   logic                     full_s;
   logic                     blocked_s;
   logic                     done_s;
   logic                     stall_s;
   logic                     issue_s;
   logic                     underflow_hit_s;
   logic                     pending_s;

   function automatic logic reg_busy(
      input logic                               vld,
      input logic [REGISTER_INDEXING_WIDTH-1:0] idx,
      input logic [COUNT_WIDTH-1:0]             cnt
   );
      reg_busy = vld && (idx != ZERO_IDX) && (cnt != ZERO_CNT);
   endfunction

   // Hazard detection and the decode/execute handshake outputs.
   always_comb begin
      hazard_s = reg_busy(sb.read_register_1_valid_in, sb.read_register_1_in,
                          cnt_r[sb.read_register_1_in])
              || reg_busy(sb.read_register_2_valid_in, sb.read_register_2_in,
                          cnt_r[sb.read_register_2_in])
              || reg_busy(sb.write_register_valid_in, sb.write_register_in,
                          cnt_r[sb.write_register_in]);
      // Redundant under in-order WAW blocking; kept so the hazard rule can be relaxed safely.
      full_s    = sb.write_register_valid_in && (sb.write_register_in != ZERO_IDX)
               && (cnt_r[sb.write_register_in] == MAX_CNT);
      blocked_s = hazard_s || full_s || sb.flush;
      done_s    = rst_n && sb.prev_done && !blocked_s;
      stall_s   = !rst_n || blocked_s || sb.next_stall;
      issue_s   = sb.prev_done && !stall_s;
   end

   // Per-register increment/decrement requests and underflow detection.
   always_comb begin
      inc_s     = {NUM_REGISTERS{1'b0}};
      dec_s     = {NUM_REGISTERS{1'b0}};
      zero_s    = {NUM_REGISTERS{1'b0}};
      pending_s = 1'b0;
      for (int r = 1; r < NUM_REGISTERS; r++) begin
         inc_s[r]  = issue_s && sb.write_register_valid_in
                  && (sb.write_register_in == REGISTER_INDEXING_WIDTH'(r));
         dec_s[r]  = sb.retire_valid && (sb.retire_register == REGISTER_INDEXING_WIDTH'(r));
         zero_s[r] = (cnt_r[r] == ZERO_CNT);
         pending_s = pending_s || !zero_s[r];
      end
      underflow_hit_s = !sb.flush && (|(dec_s & ~inc_s & zero_s));
   end

   // Pending-write counters; flush wins over any same-cycle retire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGISTERS; r++) begin
            cnt_r[r] <= ZERO_CNT;
         end
      end else if (sb.flush) begin
         for (int r = 0; r < NUM_REGISTERS; r++) begin
            cnt_r[r] <= ZERO_CNT;
         end
      end else begin
         for (int r = 0; r < NUM_REGISTERS; r++) begin
            if (inc_s[r] && !dec_s[r]) begin
               cnt_r[r] <= cnt_r[r] + ONE_CNT;
            end else if (dec_s[r] && !inc_s[r] && !zero_s[r]) begin
               cnt_r[r] <= cnt_r[r] - ONE_CNT;
            end else begin
               cnt_r[r] <= cnt_r[r];
            end
         end
      end
   end

   // Sticky underflow flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underflow_r <= 1'b0;
      end else if (underflow_hit_s) begin
         underflow_r <= 1'b1;
      end else begin
         underflow_r <= underflow_r;
      end
   end

   // Free-running count of cycles where decode was held with a valid instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_r <= 32'd0;
      end else if (sb.prev_done && stall_s) begin
         stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign sb.done_next       = done_s;
   assign sb.stall_prev      = stall_s;
   assign sb.pending_any     = pending_s;
   assign sb.underflow_error = underflow_r;
   assign sb.stall_cycles    = stall_cycles_r;
endmodule
